// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU front end.
//   - alu_op_e    : opcode encoding, one functional unit per opcode
//   - ALU_N_UNITS : number of functional units (legal opcodes 0..ALU_N_UNITS-1)
//   - ALU_OP_W    : opcode width
//   - ALU_DATA_W  : default operand width
package alu_pkg;

  localparam int ALU_OP_W    = 4;
  localparam int ALU_N_UNITS = 9;
  localparam int ALU_DATA_W  = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MP  = 4'd2,
    SLL = 4'd3,
    SRL = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    INV = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// alu_dispatch_fifo
//   Generic synchronous FIFO with synchronous flush. The head word is read
//   combinationally from storage, so a word written at edge n is visible at
//   rdata from cycle n+1.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO at the edge; beats push and pop
//   push, wdata : write request and data (ignored when full)
//   pop         : remove the head (ignored when empty)
//   rdata       : head word (undefined content when empty)
//   full, empty : status
//   count       : number of stored words
module alu_dispatch_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign rdata = mem[rd_ptr_reg[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      // Discard everything by catching the read pointer up to the write one.
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage needs no reset: empty masks its contents downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch
//   Buffered operation dispatcher in front of the ALU functional units.
//   Accepts {opcode, operand} words, queues legal ones, and presents the
//   queue head to exactly one unit selected by its opcode. Illegal opcodes
//   are dropped, pulsed on illegal_op and counted (saturating).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous queue clear (blocks accept this cycle)
//   in_valid/in_ready     : producer handshake; in_op / in_data word fields
//   unit_valid/unit_ready : per-unit handshake, unit_valid one-hot or zero
//   unit_data             : head operand shared by all units (0 when empty)
//   illegal_op            : one-cycle pulse per dropped word
//   illegal_cnt           : saturating dropped-word count
//   occupancy             : current FIFO entries
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int N_UNITS = ALU_N_UNITS,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [DATA_W-1:0]          in_data,
  output logic [N_UNITS-1:0]         unit_valid,
  input  logic [N_UNITS-1:0]         unit_ready,
  output logic [DATA_W-1:0]          unit_data,
  output logic                       illegal_op,
  output logic [7:0]                 illegal_cnt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int WORD_W = OP_W + DATA_W;
  // One extra bit so N_UNITS == 2**OP_W still compares correctly.
  localparam logic [OP_W:0] N_UNITS_L = (OP_W+1)'(N_UNITS);

  logic              fifo_full, fifo_empty;
  logic              accept, op_legal, push, pop;
  logic [WORD_W-1:0] head;
  logic [OP_W-1:0]   head_op;
  logic [DATA_W-1:0] head_data;

  logic       illegal_op_reg, illegal_op_next;
  logic [7:0] illegal_cnt_reg, illegal_cnt_next;

  // Depends only on state and flush, never on unit_ready.
  assign in_ready = !fifo_full && !flush;
  assign accept   = in_valid && in_ready;
  assign op_legal = ({1'b0, in_op} < N_UNITS_L);
  assign push     = accept && op_legal;
  assign pop      = |(unit_valid & unit_ready);

  alu_dispatch_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({in_op, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign head_op   = head[WORD_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign unit_data = fifo_empty ? '0 : head_data;

  // Request is withheld during flush so no unit can take the discarded head.
  generate
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit_sel
      assign unit_valid[gi] = !fifo_empty && !flush && (head_op == OP_W'(gi));
    end
  endgenerate

  always_comb begin
    illegal_op_next  = accept && !op_legal;
    illegal_cnt_next = illegal_cnt_reg;
    if (illegal_op_next && (illegal_cnt_reg != 8'hFF))
      illegal_cnt_next = illegal_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op_reg  <= 1'b0;
      illegal_cnt_reg <= 8'd0;
    end else begin
      illegal_op_reg  <= illegal_op_next;
      illegal_cnt_reg <= illegal_cnt_next;
    end
  end

  assign illegal_op  = illegal_op_reg;
  assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Parametrised, buffered operation dispatcher at the front of the ALU. It accepts `{opcode, operand}` words over a valid/ready handshake and queues them in a small FIFO. Each word is presented to exactly one functional unit (ADD, SUB, MP, SLL, SRL, AND, OR, XOR, INV, …) with per-unit valid/ready backpressure. Opcodes with no matching unit are dropped, flagged and counted.

## Interface
Parameters:
- `DATA_W`, 32, operand width
- `OP_W`, 4, opcode width
- `N_UNITS`, 9, number of functional units; legal opcodes are 0..N_UNITS-1; requires N_UNITS ≤ 2**OP_W
- `DEPTH`, 2, FIFO depth; power of two, ≥ 2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous queue clear
- `in_valid`  in  1  producer word valid
- `in_ready`  out  1  dispatcher can accept
- `in_op`  in  OP_W  opcode
- `in_data`  in  DATA_W  operand
- `unit_valid`  out  N_UNITS  one-hot (or zero) request to a unit
- `unit_ready`  in  N_UNITS  per-unit accept
- `unit_data`  out  DATA_W  operand of the FIFO head, shared by all units
- `illegal_op`  out  1  one-cycle pulse per dropped word
- `illegal_cnt`  out  8  saturating count of dropped words
- `occupancy`  out  $clog2(DEPTH+1)  current FIFO entries

## Operation
- Accept means `in_valid && in_ready` on a rising edge. `in_ready = !full && !flush`; it is combinational from state only and has no path from `unit_ready`.
- Legal word accepted (`in_op < N_UNITS`): push `{op, data}` into the FIFO.
- Illegal word accepted: not written. `illegal_op` = 1 next cycle. `illegal_cnt` increments and saturates at 255.
- Head presentation when the FIFO is non-empty:
  - `unit_valid[head.op] = 1` and all other bits 0.
  - `unit_data = head.data`.
- When empty: `unit_valid = 0` and `unit_data = 0`.
- Pop on `unit_valid[i] && unit_ready[i]`. `unit_ready` bits for non-selected units are ignored.
- Once asserted, `unit_valid` and `unit_data` hold stable until the pop.
- Simultaneous push and pop (not full): both occur and occupancy is unchanged.
- Wrap-around: read and write pointers are `$clog2(DEPTH)` bits plus one wrap bit. Full is pointers equal except the wrap bit; empty is pointers fully equal.
- Flush:
  - Empties the FIFO at the edge and has priority over push and pop.
  - The head is not popped to any unit.
  - `illegal_cnt` is not cleared.
  - An illegal word presented in the flush cycle is not accepted because `in_ready` = 0.
- Reset values: FIFO empty, `occupancy` 0, `unit_valid` 0, `unit_data` 0, `illegal_op` 0, `illegal_cnt` 0, `in_ready` 1.
- Reset asserted mid-operation discards all queued words immediately and asynchronously.

## Timing
- Latency: accepted at edge n into an empty FIFO → `unit_valid` high from edge n (registered head, visible in cycle n+1). There is no combinational in→unit bypass.
- Throughput: one word per cycle while the target unit holds `unit_ready` = 1.
- Full FIFO: `in_ready` = 0 until a pop edge; accept resumes the cycle after the pop.
- `illegal_op` is registered and pulses in the cycle after acceptance. Back-to-back illegal words give a continuous high.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum: ADD=0, SUB=1, MP=2, SLL=3, SRL=4, AND=5, OR=6, XOR=7, INV=8.
  - Constant `ALU_N_UNITS` = 9.
  - Default `ALU_DATA_W` = 32.
- Sub-module `alu_dispatch_fifo`: generic synchronous FIFO with parameters WIDTH and DEPTH, plus flush, full, empty and count. The top level holds decode, the illegal-op path and the counter.

## Test plan
- Reset, then push op=0 data=0x0000_1234 with `unit_ready` all 1 → next cycle `unit_valid` = 9'b0_0000_0001, `unit_data` = 0x1234; popped the same cycle, occupancy returns to 0.
- `unit_ready` = 0, push op=3 then op=8 → occupancy 2, `in_ready` = 0, `unit_valid[3]` held stable. Raise `unit_ready[8]` only → no pop. Raise `unit_ready[3]` → op 8 presented next.
- Push op=9 and op=15 back-to-back → `illegal_op` high for 2 cycles, `illegal_cnt` = 2, FIFO stays empty.
- 300 illegal words → `illegal_cnt` = 255. Flush → count stays 255. Reset → count 0.
- FIFO full, assert `flush` with `unit_ready` = 1 → next cycle occupancy 0, `unit_valid` 0, no unit handshake in the flush cycle.
- 1000 random legal and illegal words with random `unit_ready` → scoreboard confirms order preserved, every legal word delivered exactly once to unit `op`, and `illegal_cnt` matches the count of illegal words.
